// File: rtl/fixed_point_muldiv_unit_pkg.sv
// Shared constants, state/op encodings and helpers for the fixed-point
// multiply/divide unit and the OP-FP decode that feeds it.
package fixed_point_muldiv_unit_pkg;

    localparam logic [6:0] OP_FP    = 7'b1010011;
    localparam logic [6:0] F7_FMUL  = 7'b0001000;
    localparam logic [6:0] F7_FDIV  = 7'b0001100;

    localparam logic [31:0] SAT_POS   = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG   = 32'h8000_0000;
    localparam logic [31:0] DZ_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    // |0x8000_0000| comes out as 0x8000_0000, i.e. 2^31 read unsigned.
    function automatic logic [31:0] fp_abs(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/fixed_point_muldiv_unit_divider_core.sv
// Restoring unsigned divider: one shift/compare/subtract per step.
// load latches dividend/divisor; last_o flags the final step.
module fixed_point_muldiv_unit_divider_core #(
    parameter int DW = 48
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [31:0]   divisor_i,
    input  logic          step_i,
    output logic [DW-1:0] quotient_o,
    output logic          last_o
);

    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] quo_q;
    logic [31:0]   rem_q;
    logic [31:0]   dvs_q;
    logic [CW-1:0] cnt_q;

    logic [32:0]   shifted;
    logic          ge;
    logic [31:0]   diff;

    always_comb begin
        shifted = {rem_q, quo_q[DW-1]};
        ge      = shifted >= {1'b0, dvs_q};
        // remainder stays below the divisor, so the low word is exact
        diff    = shifted[31:0] - dvs_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            dvs_q <= divisor_i;
            cnt_q <= '0;
        end else if (step_i) begin
            quo_q <= {quo_q[DW-2:0], ge};
            rem_q <= ge ? diff : shifted[31:0];
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign quotient_o = quo_q;
    assign last_o     = (cnt_q == CW'(DW - 1));

endmodule

// File: rtl/fixed_point_muldiv_unit.sv
// Iterative signed fixed-point FMUL/FDIV unit with busy/result_valid handshake.
// Define FIXED_POINT_SATURATE_EN to clamp overflowing results instead of wrapping.
module fixed_point_muldiv_unit
    import fixed_point_muldiv_unit_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        overflow,
    output logic        div_zero
);

    localparam int DW = 32 + FRAC_BITS;

    state_e      state_q, state_d;
    op_e         op_q;
    logic        sign_q;
    logic        dz_q;
    logic [31:0] mcand_q;
    logic [63:0] prod_q;
    logic [5:0]  mcnt_q;
    logic        busy_q;
    logic        rv_q;
    logic [31:0] result_q;
    logic        ovf_q;
    logic        dzo_q;

    logic        unused_funct3;
    logic        accept;
    logic        is_div;
    logic        b_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_load;
    logic        div_step;
    logic        div_last;
    logic [DW-1:0] quot;
    logic [32:0] mul_sum;

    logic [63:0] mag;
    logic        neg;
    logic        ovf;
    logic [31:0] fixed_res;

    assign unused_funct3 = ^funct3;

    always_comb begin
        a_mag  = fp_abs(operand_1);
        b_mag  = fp_abs(operand_2);
        is_div = (funct7 == F7_FDIV);
        b_zero = (operand_2 == 32'd0);
        accept = start && !busy_q && (state_q == S_IDLE)
              && (opcode == OP_FP)
              && ((funct7 == F7_FMUL) || (funct7 == F7_FDIV));
        div_load = accept && is_div && !b_zero;
        div_step = (state_q == S_RUN) && (op_q == OP_DIV);
    end

    fixed_point_muldiv_unit_divider_core #(
        .DW(DW)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .load_i     (div_load),
        .dividend_i ({a_mag, {FRAC_BITS{1'b0}}}),
        .divisor_i  (b_mag),
        .step_i     (div_step),
        .quotient_o (quot),
        .last_o     (div_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (is_div && b_zero) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if ((op_q == OP_MUL && mcnt_q == 6'd31) ||
                    (op_q == OP_DIV && div_last)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Shift-add step: low half of prod_q starts as the multiplier.
    assign mul_sum = {1'b0, prod_q[63:32]}
                   + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);

    always_comb begin
        mag = (op_q == OP_DIV) ? {{(64 - DW){1'b0}}, quot}
                               : (prod_q >> FRAC_BITS);
        neg = sign_q && (mag != 64'd0);
        ovf = neg ? (mag > 64'h0000_0000_8000_0000)
                  : (mag > 64'h0000_0000_7FFF_FFFF);
        fixed_res = neg ? (32'd0 - mag[31:0]) : mag[31:0];
`ifdef FIXED_POINT_SATURATE_EN
        if (ovf) begin
            fixed_res = neg ? SAT_NEG : SAT_POS;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            sign_q   <= 1'b0;
            dz_q     <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            mcnt_q   <= '0;
            busy_q   <= 1'b0;
            rv_q     <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            dzo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            rv_q    <= (state_d == S_DONE);
            if (accept) begin
                op_q    <= is_div ? OP_DIV : OP_MUL;
                sign_q  <= operand_1[31] ^ operand_2[31];
                dz_q    <= is_div && b_zero;
                mcand_q <= a_mag;
                prod_q  <= {32'd0, b_mag};
                mcnt_q  <= '0;
            end else if (state_q == S_RUN && op_q == OP_MUL) begin
                prod_q <= {mul_sum, prod_q[31:1]};
                mcnt_q <= mcnt_q + 6'd1;
            end
            if (state_q == S_FIX) begin
                result_q <= dz_q ? DZ_RESULT : fixed_res;
                ovf_q    <= dz_q ? 1'b0 : ovf;
                dzo_q    <= dz_q;
            end
        end
    end

    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign result       = result_q;
    assign overflow     = ovf_q;
    assign div_zero     = dzo_q;

endmodule
